// File: rtl/ifft4_stream_pkg.sv
// ifft_pkg: shared widths, FSM states, complex sample types and the output
// scaler for the 4-point streaming inverse FFT.
// Optional build macro IFFT_ROUND_EN selects round-half-up with saturation in
// scale_to_out; without it the scaler is a plain floor shift.
package ifft_pkg;

  localparam int DATA_W = 16;
  localparam int N      = 4;
  // Two guard bits: a 4-term sum of DATA_W values needs DATA_W+2 bits.
  localparam int ACC_W  = DATA_W + 2;

  typedef enum logic [1:0] {
    LOAD,
    BFLY1,
    BFLY2,
    OUT
  } state_t;

  // Internal complex value at accumulator width.
  typedef struct packed {
    logic signed [ACC_W-1:0] re;
    logic signed [ACC_W-1:0] im;
  } cplx_t;

  // Complex value at interface width.
  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } sample_t;

  // Divide-by-4 of the 1/N normalisation, returning an interface-width value.
  function automatic logic signed [DATA_W-1:0] scale_to_out(
    input logic signed [ACC_W-1:0] v
  );
`ifdef IFFT_ROUND_EN
    // One extra bit: the rounding bias can push the largest sum past ACC_W.
    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((1 <<< (DATA_W-1)) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN = (ACC_W+1)'(-(1 <<< (DATA_W-1)));
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;
    biased  = (ACC_W+1)'(v) + (ACC_W+1)'(2);
    shifted = biased >>> 2;
    if (shifted > OUT_MAX) begin
      shifted = OUT_MAX;
    end else if (shifted < OUT_MIN) begin
      shifted = OUT_MIN;
    end
    return DATA_W'(shifted);
`else
    return DATA_W'(v >>> 2);
`endif
  endfunction

endpackage

// File: rtl/ifft4_stream_bfly2.sv
// ifft_bfly2: combinational radix-2 butterfly on two complex accumulator-width
// operands. Any twiddle rotation is applied by the caller before the b input.
module ifft_bfly2
  import ifft_pkg::*;
(
  input  cplx_t a_i,
  input  cplx_t b_i,
  output cplx_t sum_o,
  output cplx_t diff_o
);

  // Sum and difference of the two operands, component by component.
  always_comb begin
    sum_o.re  = a_i.re + b_i.re;
    sum_o.im  = a_i.im + b_i.im;
    diff_o.re = a_i.re - b_i.re;
    diff_o.im = a_i.im - b_i.im;
  end

endmodule

// File: rtl/ifft4_stream.sv
// ifft4_stream: streaming 4-point inverse FFT. Loads four frequency samples
// over a valid/ready input, runs two registered radix-2 stages, then drains
// four time samples in natural order over a valid/ready output.
// Optional build macro IFFT_ROUND_EN: rounded and saturated output scaling
// (implemented in ifft_pkg::scale_to_out); default build floors.
module ifft4_stream #(
  parameter int DATA_W = 16,
  parameter int N      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_real,
  input  logic signed [DATA_W-1:0] s_imag,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_real,
  output logic signed [DATA_W-1:0] m_imag,
  output logic                     m_last
);

  import ifft_pkg::*;

  if (N != 4) begin : gLengthCheck
    $error("ifft4_stream: N must be 4");
  end

  // The struct types and scaler are sized from the package, so the instance
  // width has to agree with it.
  if (DATA_W != ifft_pkg::DATA_W) begin : gWidthCheck
    $error("ifft4_stream: DATA_W must match ifft_pkg::DATA_W");
  end

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       sAccept;

  cplx_t   xMem_q   [4];
  cplx_t   aStage_q [4];
  sample_t yOut_q   [4];

  cplx_t b1Sum0, b1Diff0, b1Sum1, b1Diff1;
  cplx_t b2Sum0, b2Diff0, b2Sum1, b2Diff1;
  cplx_t jA3;

  // Stage 1 pairs X0/X2 and X1/X3.
  ifft_bfly2 uStage1Even (.a_i(xMem_q[0]), .b_i(xMem_q[2]), .sum_o(b1Sum0), .diff_o(b1Diff0));
  ifft_bfly2 uStage1Odd  (.a_i(xMem_q[1]), .b_i(xMem_q[3]), .sum_o(b1Sum1), .diff_o(b1Diff1));

  // Inverse twiddle for the odd leg: j*(r + j*i) = -i + j*r.
  always_comb begin
    jA3.re = -aStage_q[3].im;
    jA3.im = aStage_q[3].re;
  end

  // Stage 2: y0/y2 from a0 +/- a2, y1/y3 from a1 +/- j*a3.
  ifft_bfly2 uStage2Even (.a_i(aStage_q[0]), .b_i(aStage_q[2]), .sum_o(b2Sum0), .diff_o(b2Diff0));
  ifft_bfly2 uStage2Odd  (.a_i(aStage_q[1]), .b_i(jA3),         .sum_o(b2Sum1), .diff_o(b2Diff1));

  // State and index registers; reset returns to an empty LOAD phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic and handshake outputs; output data is only driven in OUT.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sAccept = 1'b0;
    s_ready = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_real  = '0;
    m_imag  = '0;
    unique case (state_q)
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          sAccept = 1'b1;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = BFLY1;
          end
        end
      end
      BFLY1: begin
        state_d = BFLY2;
      end
      BFLY2: begin
        state_d = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        m_last  = (idx_q == 2'd3);
        m_real  = yOut_q[idx_q].re;
        m_imag  = yOut_q[idx_q].im;
        if (m_ready) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Sample capture and the two pipeline stages, each enabled by its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        xMem_q[i]   <= '0;
        aStage_q[i] <= '0;
        yOut_q[i]   <= '0;
      end
    end else begin
      if (sAccept) begin
        xMem_q[idx_q].re <= ACC_W'(s_real);
        xMem_q[idx_q].im <= ACC_W'(s_imag);
      end
      if (state_q == BFLY1) begin
        aStage_q[0] <= b1Sum0;
        aStage_q[1] <= b1Diff0;
        aStage_q[2] <= b1Sum1;
        aStage_q[3] <= b1Diff1;
      end
      if (state_q == BFLY2) begin
        yOut_q[0].re <= scale_to_out(b2Sum0.re);
        yOut_q[0].im <= scale_to_out(b2Sum0.im);
        yOut_q[1].re <= scale_to_out(b2Sum1.re);
        yOut_q[1].im <= scale_to_out(b2Sum1.im);
        yOut_q[2].re <= scale_to_out(b2Diff0.re);
        yOut_q[2].im <= scale_to_out(b2Diff0.im);
        yOut_q[3].re <= scale_to_out(b2Diff1.re);
        yOut_q[3].im <= scale_to_out(b2Diff1.im);
      end
    end
  end

endmodule

// File: tb/tb_ifft4_stream.sv
// tb_ifft4_stream: randomized self-checking bench for ifft4_stream against a
// direct-sum inverse DFT reference. Honours IFFT_ROUND_EN when defined.
`timescale 1ns/1ps
module tb_ifft4_stream;

  localparam int DATA_W = 16;
  typedef int arr4_t [4];

  logic clk = 1'b0;
  logic reset;
  logic s_valid;
  logic s_ready;
  logic signed [DATA_W-1:0] s_real;
  logic signed [DATA_W-1:0] s_imag;
  logic m_valid;
  logic m_ready;
  logic signed [DATA_W-1:0] m_real;
  logic signed [DATA_W-1:0] m_imag;
  logic m_last;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  ifft4_stream #(.DATA_W(DATA_W), .N(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_real (s_real),
    .s_imag (s_imag),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_real (m_real),
    .m_imag (m_imag),
    .m_last (m_last)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Output normalisation by 1/4.
  function automatic int scaleRef(input int acc);
    int v;
`ifdef IFFT_ROUND_EN
    v = (acc + 2) >>> 2;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`else
    v = acc >>> 2;
`endif
    return v;
  endfunction

  // x[n] = 1/4 * sum_k X[k] * j^(n*k)  (W^-1 = +j for N=4).
  task automatic refIfft(input arr4_t xr, input arr4_t xi, output arr4_t yr, output arr4_t yi);
    for (int n = 0; n < 4; n++) begin
      int accR = 0;
      int accI = 0;
      for (int k = 0; k < 4; k++) begin
        case ((n * k) % 4)
          0: begin accR += xr[k]; accI += xi[k]; end
          1: begin accR -= xi[k]; accI += xr[k]; end
          2: begin accR -= xr[k]; accI -= xi[k]; end
          default: begin accR += xi[k]; accI -= xr[k]; end
        endcase
      end
      yr[n] = scaleRef(accR);
      yi[n] = scaleRef(accI);
    end
  endtask

  // Drive one frame of four samples, optionally with random s_valid gaps.
  task automatic applyStimulus(input arr4_t xr, input arr4_t xi, input bit allowGaps);
    int k = 0;
    int cycles = 0;
    bit held = 1'b0;
    while (k < 4 && cycles < 100) begin
      @(negedge clk);
      if (!held && allowGaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_real  = DATA_W'(xr[k]);
        s_imag  = DATA_W'(xi[k]);
      end
      held = s_valid && !s_ready;
      if (s_valid && s_ready) k++;
      cycles++;
    end
    if (k < 4) checkOutput("load_timeout", k, 4);
  endtask

  // Collect four outputs under random or forced backpressure and compare.
  task automatic drainFrame(input arr4_t yr, input arr4_t yi, input bit stallMid);
    int lat = 1;
    int n = 0;
    int cycles = 0;
    int stall = 0;
    bit stallDone = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    while (!m_valid && lat < 20) begin
      checkOutput("s_ready_busy", s_ready, 0);
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", lat, 3);
    while (n < 4 && cycles < 200) begin
      if (stallMid && n == 2 && !stallDone) begin
        stall = 5;
        stallDone = 1'b1;
      end
      if (stall > 0) begin
        m_ready = 1'b0;
        stall--;
      end else begin
        m_ready = ($urandom_range(0, 3) != 0);
      end
      checkOutput("m_valid", m_valid, 1);
      checkOutput("s_ready_out", s_ready, 0);
      checkOutput($sformatf("m_real[%0d]", n), m_real, yr[n]);
      checkOutput($sformatf("m_imag[%0d]", n), m_imag, yi[n]);
      checkOutput($sformatf("m_last[%0d]", n), m_last, (n == 3) ? 1 : 0);
      if (m_ready) n++;
      cycles++;
      @(negedge clk);
    end
    m_ready = 1'b0;
    if (n < 4) checkOutput("drain_timeout", n, 4);
    checkOutput("m_valid_after", m_valid, 0);
    checkOutput("s_ready_after", s_ready, 1);
  endtask

  task automatic runFrame(input arr4_t xr, input arr4_t xi, input bit allowGaps, input bit stallMid);
    arr4_t yr;
    arr4_t yi;
    refIfft(xr, xi, yr, yi);
    applyStimulus(xr, xi, allowGaps);
    drainFrame(yr, yi, stallMid);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    checkOutput("rst_s_ready", s_ready, 1);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_last", m_last, 0);
    checkOutput("rst_m_real", m_real, 0);
    checkOutput("rst_m_imag", m_imag, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    arr4_t xr;
    arr4_t xi;
    int waitCycles;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_real  = '0;
    s_imag  = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    pulseReset();

    $display("[TB] impulse");
    xr = '{400, 0, 0, 0};         xi = '{0, 0, 0, 0};
    runFrame(xr, xi, 1'b0, 1'b0);

    $display("[TB] shifted impulse with input gaps");
    xr = '{0, 400, 0, 0};         xi = '{0, 0, 0, 0};
    runFrame(xr, xi, 1'b1, 1'b0);

    $display("[TB] dc in frequency with mid-drain stall");
    xr = '{400, 400, 400, 400};   xi = '{0, 0, 0, 0};
    runFrame(xr, xi, 1'b0, 1'b1);

    $display("[TB] rounding corner");
    xr = '{-2, 0, 0, 0};          xi = '{2, 0, 0, 0};
    runFrame(xr, xi, 1'b0, 1'b0);

    $display("[TB] positive full scale");
    xr = '{32767, 32767, 32767, 32767}; xi = '{0, 0, 0, 0};
    runFrame(xr, xi, 1'b0, 1'b0);

    $display("[TB] negative full scale");
    xr = '{-32768, -32768, -32768, -32768}; xi = '{-32768, -32768, -32768, -32768};
    runFrame(xr, xi, 1'b1, 1'b1);

    $display("[TB] alternating extremes");
    xr = '{32767, -32768, -32768, 32767}; xi = '{-32768, 32767, -32768, 32767};
    runFrame(xr, xi, 1'b0, 1'b0);

    $display("[TB] reset after two input transfers");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_real  = DATA_W'(1000 + i);
      s_imag  = DATA_W'(-77);
    end
    pulseReset();
    xr = '{400, 0, 0, 0};         xi = '{0, 0, 0, 0};
    runFrame(xr, xi, 1'b0, 1'b0);

    $display("[TB] reset during drain");
    xr = '{123, -456, 789, -1011}; xi = '{5, 6, 7, 8};
    applyStimulus(xr, xi, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    waitCycles = 0;
    while (!m_valid && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("drain_reached", m_valid, 1);
    pulseReset();
    xr = '{0, 400, 0, 0};         xi = '{0, 0, 0, 0};
    runFrame(xr, xi, 1'b1, 1'b0);

    $display("[TB] random frames");
    for (int f = 0; f < 24; f++) begin
      for (int k = 0; k < 4; k++) begin
        xr[k] = int'($urandom_range(0, 65535)) - 32768;
        xi[k] = int'($urandom_range(0, 65535)) - 32768;
      end
      runFrame(xr, xi, ($urandom_range(0, 1) == 1), (f % 4 == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
